local_bus_responder: RTL and testbench
======================================

Name: local_bus_responder

Overview:
- Slave end of the local parallel bus driven by the USB host interface: subadd, data, n_write, n_read, n_sync and n_wait.
- Holds 16 read/write control registers, an ID byte and a status byte.
- Holds a byte readout FIFO filled by detector logic.
- Raises active-low interrupt and read_req lines toward the host interface and answers the host's read-request burst on subaddress 0x7F.

Parameters:
FIFO_AW, 8, FIFO address width; depth = 2**FIFO_AW bytes
ID_VALUE, 8'hA5, constant returned at subaddress 0x10
RR_THRESHOLD, 16, FIFO level at or above which read_req is asserted (1..2**FIFO_AW)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active high
subadd  in  7  subaddress from bus master
data  inout  8  bidirectional bus data
n_write  in  1  active-low write strobe
n_read  in  1  active-low read strobe
n_sync  in  1  active-low transaction frame
n_wait  out  1  active-low wait to master
interrupt  out  1  active-low interrupt request
read_req  out  1  active-low read request
fifo_din  in  8  readout byte from detector logic
fifo_wr  in  1  push fifo_din (one byte per cycle)
fifo_full  out  1  FIFO full
ctrl_regs  out  128  control registers 0..15, reg k at bits [8k+7:8k]
ctrl_wr_pulse  out  16  one-cycle pulse per register written
event_in  in  1  sets interrupt-pending on any cycle it is 1

Behaviour:
- Reset (async, high): ctrl_regs=0, ctrl_wr_pulse=0, FIFO empty, fifo_full=0, interrupt=1, read_req=1, n_wait=1, data=Z, overflow=0, pending=0, RR state IDLE. Reset mid-burst abandons the burst; no byte is popped.
- Transfer rule: one byte transfers on each rising clk with n_sync=0, the strobe=0 and n_wait=1. A strobe held for k cycles transfers k bytes. n_write and n_read are never both low; if both are low, both are ignored.
- Writes:
  - data sampled at the transfer edge.
  - 0x00-0x0F: store to ctrl reg; ctrl_wr_pulse[k]=1 the following cycle only.
  - 0x12: bit0=1 clears pending, bit1=1 clears overflow.
  - All other subaddresses: ignored.
- Reads:
  - data is driven only while n_sync=0 and n_read=0; otherwise Z.
  - Read data is combinational from subadd and state; zero latency.
  - 0x00-0x0F: ctrl reg.
  - 0x10: ID_VALUE.
  - 0x11: status {4'b0, overflow, pending, fifo_full, empty}.
  - 0x20: FIFO head (first-word fall-through); the transfer edge pops it.
  - 0x21: min(count,255).
  - 0x7F: RR protocol, below.
  - Unmapped: 8'h00.
- n_wait: 0 only while n_sync=0, n_read=0, subadd=0x20 and FIFO empty; 1 in every other case. Combinational.
- FIFO:
  - Push when fifo_wr=1 and not full.
  - Push while full is dropped and sets overflow (sticky).
  - Simultaneous push and pop: count unchanged, both performed. Allowed when full: the pop frees the slot.
  - Pointers wrap modulo depth.
  - count is FIFO_AW+1 bits; fifo_full = (count == 2**FIFO_AW).
- read_req = 0 while count >= RR_THRESHOLD and RR state is IDLE; else 1. Registered, 1 cycle after the count change.
- interrupt = ~pending, registered. A simultaneous event_in and clear leaves pending set.
- RR state machine, subaddress 0x7F:
  - IDLE -> HDR: on n_sync falling edge (registered detect) with subadd=0x7F.
  - HDR: read returns N = min(count,255) sampled combinationally. Transfer edge latches remaining=N and goes to BURST, or to IDLE if N=0.
  - BURST: read returns FIFO head. Each transfer pops and decrements remaining. remaining reaches 0 -> IDLE.
  - Any state -> IDLE when n_sync=1. Unread bytes stay in the FIFO.
  - Pushes during BURST do not extend N.
- 0x7F reads in IDLE return 8'h00.

Test Plan:
- Reset, then n_sync=0, write 0x3C to 0x05, read 0x05 and 0x10 -> ctrl_regs[47:40]=0x3C; ctrl_wr_pulse[5] high exactly 1 cycle; reads return 0x3C and 0xA5; data Z whenever n_read=1.
- Push 3 bytes 0x11,0x22,0x33; read 0x20 with n_read held low 4 cycles -> bytes 0x11,0x22,0x33, then n_wait=0 on the 4th cycle; a push then releases n_wait the same cycle with the new byte on data.
- Push 16 bytes -> read_req=0 one cycle after the 16th push. 0x7F burst -> header 0x10 then 16 bytes in order, read_req=1, empty=1. Repeat with n_sync raised after 5 bytes -> 11 remain, read_req=1.
- Fill to 256, push 1 more -> fifo_full=1, status=0x0A, count 256. Simultaneous push+pop while full -> count stays 256, order preserved. Write 0x02 to 0x12 -> overflow=0.
- Pulse event_in -> interrupt=0 next cycle. Write 0x01 to 0x12 in the same cycle as event_in -> interrupt stays 0. Clear again alone -> interrupt=1.
- Assert reset during BURST after 2 of 10 bytes -> all outputs at reset values immediately; FIFO empty, RR IDLE, data Z.

Source files
------------

// File: rtl/local_bus_responder.sv
// Slave end of the local parallel bus: control registers, ID/status, a byte
// readout FIFO and the 0x7F read-request burst toward the USB host interface.
module local_bus_responder #(
    parameter int unsigned FIFO_AW      = 8,
    parameter logic [7:0]  ID_VALUE     = 8'hA5,
    parameter int unsigned RR_THRESHOLD = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [6:0]   subadd,
    inout  wire  [7:0]   data,
    input  logic         n_write,
    input  logic         n_read,
    input  logic         n_sync,
    output logic         n_wait,
    output logic         interrupt,
    output logic         read_req,
    input  logic [7:0]   fifo_din,
    input  logic         fifo_wr,
    output logic         fifo_full,
    output logic [127:0] ctrl_regs,
    output logic [15:0]  ctrl_wr_pulse,
    input  logic         event_in
);
    localparam int unsigned DEPTH = 2**FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [6:0] SA_ID     = 7'h10;
    localparam logic [6:0] SA_STATUS = 7'h11;
    localparam logic [6:0] SA_CLEAR  = 7'h12;
    localparam logic [6:0] SA_FIFO   = 7'h20;
    localparam logic [6:0] SA_LEVEL  = 7'h21;
    localparam logic [6:0] SA_RR     = 7'h7F;

    typedef enum logic [1:0] {RR_IDLE, RR_HDR, RR_BURST} rr_state_t;
    rr_state_t rr_state, rr_state_nxt;

    logic [15:0][7:0]   ctrl_q;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic [7:0]         remaining;
    logic               overflow, pending, n_sync_q;

    logic       empty_c, full_c, n_wait_c, drive_c;
    logic       xfer_rd_c, xfer_wr_c, rr_xfer_c, push_c, pop_c;
    logic       clr_pend_c, clr_ovf_c, pending_nxt_c;
    logic [7:0] level_c, head_c, rd_data_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign level_c   = (32'(count) > 32'd255) ? 8'hFF : 8'(count);
    assign head_c    = mem[rd_ptr];

    // Stall only a FIFO read that finds nothing to return; reset forces release.
    assign n_wait_c  = reset | ~(~n_sync & ~n_read & (subadd == SA_FIFO) & empty_c);
    assign drive_c   = ~reset & ~n_sync & ~n_read;
    assign xfer_rd_c = ~n_sync & ~n_read & n_write & n_wait_c;
    assign xfer_wr_c = ~n_sync & ~n_write & n_read & n_wait_c;
    assign rr_xfer_c = xfer_rd_c & (subadd == SA_RR);

    assign pop_c     = xfer_rd_c & ~empty_c &
                       ((subadd == SA_FIFO) | ((subadd == SA_RR) & (rr_state == RR_BURST)));
    assign push_c    = fifo_wr & (~full_c | pop_c);

    assign clr_pend_c    = xfer_wr_c & (subadd == SA_CLEAR) & data[0];
    assign clr_ovf_c     = xfer_wr_c & (subadd == SA_CLEAR) & data[1];
    assign pending_nxt_c = event_in | (pending & ~clr_pend_c);

    assign n_wait    = n_wait_c;
    assign fifo_full = full_c;
    assign ctrl_regs = ctrl_q;
    assign data      = drive_c ? rd_data_c : 8'hzz;

    // Zero-latency read data
    always_comb begin
        rd_data_c = 8'h00;
        if (subadd[6:4] == 3'b000) begin
            rd_data_c = ctrl_q[subadd[3:0]];
        end else begin
            case (subadd)
                SA_ID:     rd_data_c = ID_VALUE;
                SA_STATUS: rd_data_c = {4'b0000, overflow, pending, full_c, empty_c};
                SA_FIFO:   rd_data_c = head_c;
                SA_LEVEL:  rd_data_c = level_c;
                SA_RR: begin
                    if (rr_state == RR_HDR)        rd_data_c = level_c;
                    else if (rr_state == RR_BURST) rd_data_c = head_c;
                end
                default: ;
            endcase
        end
    end

    // Read-request burst sequencing; dropping the frame always abandons it
    always_comb begin
        rr_state_nxt = rr_state;
        if (n_sync) begin
            rr_state_nxt = RR_IDLE;
        end else begin
            case (rr_state)
                RR_IDLE:  if (n_sync_q && (subadd == SA_RR)) rr_state_nxt = RR_HDR;
                RR_HDR:   if (rr_xfer_c) rr_state_nxt = (level_c == 8'd0) ? RR_IDLE : RR_BURST;
                RR_BURST: if (rr_xfer_c && (remaining == 8'd1)) rr_state_nxt = RR_IDLE;
                default:  rr_state_nxt = RR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_state <= RR_IDLE;
        else       rr_state <= rr_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= fifo_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q        <= '0;
            ctrl_wr_pulse <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            remaining     <= '0;
            overflow      <= 1'b0;
            pending       <= 1'b0;
            interrupt     <= 1'b1;
            read_req      <= 1'b1;
            n_sync_q      <= 1'b1;
        end else begin
            ctrl_wr_pulse <= '0;
            if (xfer_wr_c && (subadd[6:4] == 3'b000)) begin
                ctrl_q[subadd[3:0]]        <= data;
                ctrl_wr_pulse[subadd[3:0]] <= 1'b1;
            end
            if (push_c) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_c)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (rr_xfer_c && (rr_state == RR_HDR))   remaining <= level_c;
            if (rr_xfer_c && (rr_state == RR_BURST)) remaining <= remaining - 8'd1;
            overflow  <= (fifo_wr & ~push_c) | (overflow & ~clr_ovf_c);
            pending   <= pending_nxt_c;
            interrupt <= ~pending_nxt_c;
            read_req  <= ~((32'(count) >= RR_THRESHOLD) && (rr_state == RR_IDLE));
            n_sync_q  <= n_sync;
        end
    end
endmodule

// File: tb/tb_local_bus_responder.sv
// Self-checking bench for local_bus_responder: register vector table plus
// FIFO / read-request sequences checked against a byte scoreboard.
module tb_local_bus_responder;
    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   subadd;
    wire  [7:0]   data;
    logic [7:0]   tb_data;
    logic         tb_drive;
    logic         n_write, n_read, n_sync, event_in, fifo_wr;
    logic [7:0]   fifo_din;
    logic         n_wait, interrupt, read_req, fifo_full;
    logic [127:0] ctrl_regs;
    logic [15:0]  ctrl_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [7:0]       sb[$];
    logic [15:0][7:0] m_ctrl;

    typedef struct {
        logic        wr;
        logic [6:0]  sa;
        logic [7:0]  val;
        logic [15:0] pulse;
    } vec_t;
    vec_t vecs[17];

    assign data = tb_drive ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    local_bus_responder #(.FIFO_AW(8), .ID_VALUE(8'hA5), .RR_THRESHOLD(16)) dut (
        .clk(clk), .reset(reset), .subadd(subadd), .data(data),
        .n_write(n_write), .n_read(n_read), .n_sync(n_sync), .n_wait(n_wait),
        .interrupt(interrupt), .read_req(read_req), .fifo_din(fifo_din),
        .fifo_wr(fifo_wr), .fifo_full(fifo_full), .ctrl_regs(ctrl_regs),
        .ctrl_wr_pulse(ctrl_wr_pulse), .event_in(event_in)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_released(input string name);
        checks++;
        if (!(data === 8'hzz || data === 8'h00)) begin
            errors++;
            $display("FAIL %s: data=%h expected released bus", name, data);
        end
    endtask

    task automatic chk_head(input string name);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, data=%h", name, data);
        end else begin
            chk(name, 128'(data), 128'(sb.pop_front()));
        end
    endtask

    task automatic bus_write(input logic [6:0] sa, input logic [7:0] d);
        subadd = sa; tb_data = d; tb_drive = 1'b1; n_write = 1'b0;
        tick();
        n_write = 1'b1; tb_drive = 1'b0;
    endtask

    task automatic bus_read_chk(input string name, input logic [6:0] sa, input logic [7:0] exp);
        subadd = sa; n_read = 1'b0;
        #1;
        chk(name, 128'(data), 128'(exp));
        n_read = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] d);
        fifo_din = d; fifo_wr = 1'b1;
        tick();
        fifo_wr = 1'b0;
        sb.push_back(d);
    endtask

    task automatic drain(input string name, input int n);
        subadd = 7'h20; n_read = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk_head(name);
            tick();
        end
        n_read = 1'b1;
    endtask

    task automatic start_rr();
        n_sync = 1'b1; n_read = 1'b1;
        tick();
        subadd = 7'h7F; n_sync = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; subadd = 7'h10; tb_data = 8'h00; tb_drive = 1'b0;
        n_write = 1'b1; n_read = 1'b1; n_sync = 1'b0; event_in = 1'b0;
        fifo_wr = 1'b0; fifo_din = 8'h00; m_ctrl = '0;
        tick(); tick();

        // Reset state
        chk("rst_interrupt", 128'(interrupt), 128'(1'b1));
        chk("rst_read_req", 128'(read_req), 128'(1'b1));
        chk("rst_n_wait", 128'(n_wait), 128'(1'b1));
        chk("rst_fifo_full", 128'(fifo_full), 128'(1'b0));
        chk("rst_ctrl_regs", ctrl_regs, 128'(0));
        chk("rst_pulse", 128'(ctrl_wr_pulse), 128'(0));
        chk_released("rst_data");
        reset = 1'b0; subadd = 7'h00;
        tick();

        // Basic write / read-back
        bus_write(7'h05, 8'h3C);
        m_ctrl[5] = 8'h3C;
        chk("wr5_reg", 128'(ctrl_regs[47:40]), 128'(8'h3C));
        chk("wr5_pulse", 128'(ctrl_wr_pulse), 128'(16'h0020));
        tick();
        chk("wr5_pulse_gone", 128'(ctrl_wr_pulse), 128'(16'h0000));
        bus_read_chk("rd5", 7'h05, 8'h3C);
        bus_read_chk("rd_id", 7'h10, 8'hA5);
        subadd = 7'h10; #1;
        chk_released("data_no_read");
        n_sync = 1'b1; n_read = 1'b0; #1;
        chk_released("data_no_sync");
        n_read = 1'b1;
        tick();
        subadd = 7'h05; n_sync = 1'b0;
        tick();

        vecs[0]  = '{1'b1, 7'h00, 8'h81, 16'h0001};
        vecs[1]  = '{1'b1, 7'h0F, 8'h7E, 16'h8000};
        vecs[2]  = '{1'b1, 7'h0A, 8'h00, 16'h0400};
        vecs[3]  = '{1'b1, 7'h13, 8'hFF, 16'h0000};
        vecs[4]  = '{1'b1, 7'h10, 8'h12, 16'h0000};
        vecs[5]  = '{1'b0, 7'h00, 8'h81, 16'h0000};
        vecs[6]  = '{1'b0, 7'h0F, 8'h7E, 16'h0000};
        vecs[7]  = '{1'b0, 7'h05, 8'h3C, 16'h0000};
        vecs[8]  = '{1'b0, 7'h0A, 8'h00, 16'h0000};
        vecs[9]  = '{1'b0, 7'h10, 8'hA5, 16'h0000};
        vecs[10] = '{1'b0, 7'h11, 8'h01, 16'h0000};
        vecs[11] = '{1'b0, 7'h21, 8'h00, 16'h0000};
        vecs[12] = '{1'b0, 7'h7F, 8'h00, 16'h0000};
        vecs[13] = '{1'b0, 7'h40, 8'h00, 16'h0000};
        vecs[14] = '{1'b0, 7'h13, 8'h00, 16'h0000};
        vecs[15] = '{1'b1, 7'h12, 8'h03, 16'h0000};
        vecs[16] = '{1'b0, 7'h11, 8'h01, 16'h0000};
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].sa, vecs[i].val);
                if (vecs[i].sa[6:4] == 3'b000) m_ctrl[vecs[i].sa[3:0]] = vecs[i].val;
                chk($sformatf("vec%0d_pulse", i), 128'(ctrl_wr_pulse), 128'(vecs[i].pulse));
                chk($sformatf("vec%0d_ctrl", i), ctrl_regs, 128'(m_ctrl));
                tick();
            end else begin
                bus_read_chk($sformatf("vec%0d_read", i), vecs[i].sa, vecs[i].val);
            end
        end

        // FIFO first-word fall-through and wait on empty
        push(8'h11); push(8'h22); push(8'h33);
        subadd = 7'h20; n_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fifo_n_wait_hi", 128'(n_wait), 128'(1'b1));
            chk_head("fifo_read");
            tick();
        end
        #1;
        chk("fifo_n_wait_empty", 128'(n_wait), 128'(1'b0));
        fifo_din = 8'h44; fifo_wr = 1'b1;
        tick();
        fifo_wr = 1'b0; sb.push_back(8'h44);
        #1;
        chk("fifo_n_wait_release", 128'(n_wait), 128'(1'b1));
        chk_head("fifo_read_late");
        tick();
        n_read = 1'b1;
        bus_read_chk("fifo_status_empty", 7'h11, 8'h01);

        // Full read-request burst
        for (int i = 0; i < 15; i++) push(8'(8'h40 + i));
        tick();
        chk("rr_below_thresh", 128'(read_req), 128'(1'b1));
        push(8'h4F);
        chk("rr_one_cycle_late", 128'(read_req), 128'(1'b1));
        tick();
        chk("rr_asserted", 128'(read_req), 128'(1'b0));
        start_rr();
        n_read = 1'b0; #1;
        chk("rr_header16", 128'(data), 128'(8'h10));
        tick();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk_head("rr_burst");
            tick();
        end
        #1;
        chk("rr_idle_read", 128'(data), 128'(8'h00));
        n_read = 1'b1;
        tick();
        chk("rr_after_burst", 128'(read_req), 128'(1'b1));
        bus_read_chk("rr_status_empty", 7'h11, 8'h01);

        // Burst abandoned after 5 bytes
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        tick();
        chk("rr2_asserted", 128'(read_req), 128'(1'b0));
        start_rr();
        n_read = 1'b0; #1;
        chk("rr2_header", 128'(data), 128'(8'h10));
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_head("rr2_burst");
            tick();
        end
        n_sync = 1'b1; n_read = 1'b1;
        tick(); tick();
        chk("rr2_read_req", 128'(read_req), 128'(1'b1));
        subadd = 7'h21; n_sync = 1'b0;
        bus_read_chk("rr2_level", 7'h21, 8'h0B);
        drain("rr2_drain", 11);

        // Fill, overflow, push+pop while full
        for (int i = 0; i < 256; i++) push(8'($urandom));
        chk("full_flag", 128'(fifo_full), 128'(1'b1));
        fifo_din = 8'hEE; fifo_wr = 1'b1;
        tick();
        fifo_wr = 1'b0;
        chk("full_after_drop", 128'(fifo_full), 128'(1'b1));
        bus_read_chk("ovf_status", 7'h11, 8'h0A);
        bus_read_chk("full_level", 7'h21, 8'hFF);
        subadd = 7'h20; n_read = 1'b0; fifo_din = 8'h5A; fifo_wr = 1'b1;
        #1;
        chk_head("full_pushpop");
        tick();
        sb.push_back(8'h5A);
        fifo_wr = 1'b0; n_read = 1'b1;
        chk("full_pushpop_flag", 128'(fifo_full), 128'(1'b1));
        bus_write(7'h12, 8'h02);
        bus_read_chk("ovf_cleared", 7'h11, 8'h02);
        drain("full_drain", 256);
        chk("drained_full", 128'(fifo_full), 128'(1'b0));
        bus_read_chk("drained_status", 7'h11, 8'h01);

        // Interrupt pending / clear
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        chk("irq_set", 128'(interrupt), 128'(1'b0));
        bus_read_chk("irq_status", 7'h11, 8'h05);
        event_in = 1'b1;
        bus_write(7'h12, 8'h01);
        event_in = 1'b0;
        chk("irq_set_wins", 128'(interrupt), 128'(1'b0));
        bus_write(7'h12, 8'h01);
        chk("irq_cleared", 128'(interrupt), 128'(1'b1));
        bus_read_chk("irq_status_clr", 7'h11, 8'h01);

        // Reset in the middle of a burst
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
        start_rr();
        n_read = 1'b0; #1;
        chk("rst_burst_header", 128'(data), 128'(8'h0A));
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_head("rst_burst");
            tick();
        end
        reset = 1'b1; subadd = 7'h10;
        #1;
        chk("mid_rst_interrupt", 128'(interrupt), 128'(1'b1));
        chk("mid_rst_read_req", 128'(read_req), 128'(1'b1));
        chk("mid_rst_full", 128'(fifo_full), 128'(1'b0));
        chk("mid_rst_ctrl", ctrl_regs, 128'(0));
        chk("mid_rst_pulse", 128'(ctrl_wr_pulse), 128'(0));
        chk("mid_rst_n_wait", 128'(n_wait), 128'(1'b1));
        chk_released("mid_rst_data");
        sb.delete();
        n_read = 1'b1; n_sync = 1'b1; subadd = 7'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_sync = 1'b0;
        bus_read_chk("post_rst_status", 7'h11, 8'h01);
        bus_read_chk("post_rst_level", 7'h21, 8'h00);
        bus_read_chk("post_rst_rr_idle", 7'h7F, 8'h00);
        chk("post_rst_ctrl", ctrl_regs, 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
